seq_array_mult: RTL and testbench
=================================

# seq_array_mult

Sequential, parametrised array multiplier: accepts one WIDTH×WIDTH operand pair over a valid/ready handshake and accumulates ROWS_PER_CYCLE AND-and-add partial-product rows per clock. Adds a signed (two's-complement) mode and output backpressure. Replaces fully unrolled row arrays where area matters more than latency. Sits between an operand-issuing datapath and a result consumer.

## Interface
- WIDTH, 8, operand width in bits; ≥ 2.
- ROWS_PER_CYCLE, 1, partial-product rows folded per cycle; must divide WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned. Sampled with a and b.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result; two's complement when signed_mode was 1.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid && in_ready, register the operands and go to RUN.
  - Unsigned: register a and b as-is.
  - Signed: register |a|, |b| and neg = a[MSB] ^ b[MSB]. The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1) and fits in WIDTH unsigned bits.
  - Clear the accumulator and the row counter.
- RUN: each cycle, process rows k .. k+ROWS_PER_CYCLE−1:
  - Row i adds (a_reg AND {WIDTH{b_reg[i]}}) << i into the 2*WIDTH-bit accumulator.
  - Then k += ROWS_PER_CYCLE.
  - When k reaches WIDTH: load product = neg ? −acc : acc (mod 2^(2*WIDTH)) and go to DONE.
- DONE: out_valid=1.
  - product is held stable until out_valid && out_ready, then go to IDLE.
  - No new operands are accepted in RUN or DONE (in_ready=0).
- Arithmetic: the accumulator is 2*WIDTH bits and never overflows. Signed result range is exact, e.g. (−2^(W−1))² = 2^(2W−2).
- in_valid while not in IDLE: ignored; the upstream must hold its operands.
- Reset, asserted at any time, including mid-RUN or DONE:
  - State goes to IDLE and the in-flight operation is discarded.
  - Reset values: in_ready=0 while rst_n=0, then 1 from the first cycle after deassertion. out_valid=0, busy=0, product=0.
  - Accumulator, counter and operand registers clear to 0.

## Timing
- N = WIDTH/ROWS_PER_CYCLE.
- Accept edge E0. RUN occupies the N cycles after E0. out_valid rises after edge E_N, so latency is N cycles from the accept edge.
- Throughput: one product per N+2 cycles with out_ready held high (accept, N RUN cycles, DONE handshake, back in IDLE).
- in_ready, out_valid and busy are registered FSM decodes. There is no combinational path from out_ready or in_valid to any output.
- The handshake completing in DONE makes in_ready=1 on the next cycle. Same-cycle turnaround is not supported.

## Structure
- Package seq_mult_pkg holds:
  - the state enum type (IDLE, RUN, DONE);
  - a function returning the cycle count N for given WIDTH and ROWS_PER_CYCLE.
- Sub-module mult_row_p: parametrised combinational AND+adder row.
  - Inputs: accumulator slice, a_reg, one b bit, carry-in.
  - Outputs: sum and carry.
  - Instantiated ROWS_PER_CYCLE times in a chain inside seq_array_mult.
- Top module holds the FSM, counter, operand/accumulator registers and sign fix-up.

## Test plan
- WIDTH=8, R=1, unsigned 13×11 → product=143 (0x008F); out_valid rises 8 cycles after the accept edge; in_ready=0 throughout.
- Unsigned 255×255 → 0xFE01; unsigned 0×200 → 0x0000.
- Signed: −128×−128 → 0x4000; −3×5 → 0xFFF1; 127×−1 → 0xFF81. Also 0xFD×0x05 with signed_mode=0 → 0x04F1 (mode matters).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → product and out_valid stable, in_ready=0, new in_valid ignored. Then release → one transfer, IDLE next cycle.
- Reset: deassert rst_n at RUN cycle 3 → next cycle all outputs at reset values. After release, 6×7 → 42 with normal latency.
- WIDTH=16, R=4: 1000×1000 → 1000000 (0x000F4240) after 4 cycles. Back-to-back operations with out_ready=1 complete every 6 cycles.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential array multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Number of RUN cycles needed to fold all partial-product rows.
   function automatic int unsigned num_cycles(input int unsigned width,
                                              input int unsigned rows);
      return width / rows;
   endfunction

endpackage

// File: rtl/seq_array_mult_if.sv
// Operand/result handshake bundle between issuing datapath, multiplier and consumer.
interface seq_array_mult_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   signed_mode;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     product;
   logic                   busy;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, product, busy
   );

endinterface

// File: rtl/mult_row_p.sv
// One AND-and-add partial-product row: sum/carry = acc_slice + (a_op & b_bit) + carry_in.
module mult_row_p #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] acc_slice,
   input  logic [WIDTH-1:0] a_op,
   input  logic             b_bit,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH-1:0] pp;
   logic [WIDTH:0]   total;

   // Gate the multiplicand by the multiplier bit and add it into the slice.
   always_comb begin
      pp    = a_op & {WIDTH{b_bit}};
      total = {1'b0, acc_slice} + {1'b0, pp} + {{WIDTH{1'b0}}, carry_in};
   end

   assign sum   = total[WIDTH-1:0];
   assign carry = total[WIDTH];

endmodule

// File: rtl/seq_array_mult.sv
// Sequential array multiplier: folds ROWS_PER_CYCLE partial-product rows per clock,
// with optional two's-complement operands and output backpressure.
module seq_array_mult
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned ROWS_PER_CYCLE = 1
) (
   input logic             clk,
   input logic             rst_n,
   seq_array_mult_if.slave bus
);

   localparam int unsigned NumCycles = num_cycles(WIDTH, ROWS_PER_CYCLE);
   localparam int unsigned CntW      = $clog2(NumCycles + 1);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [CntW-1:0]      cyc_q, cyc_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic                 busy_q, busy_d;
   logic [WIDTH-1:0]     row_hi, row_lo;
   logic [2*WIDTH-1:0]   acc_next;

   // Shift-add form: the accumulator shifts right one bit per row, so row i's
   // "<< i" is implicit and the previous carry already sits in the top bit of
   // the high slice; the external carry-in is therefore unused.
   for (genvar j = 0; j < ROWS_PER_CYCLE; j++) begin : g_row
      logic [WIDTH-1:0] hi_in, lo_in, hi_out, lo_out, row_sum;
      logic             row_carry;

      if (j == 0) begin : g_first
         assign hi_in = acc_hi_q;
         assign lo_in = acc_lo_q;
      end else begin : g_next
         assign hi_in = g_row[j-1].hi_out;
         assign lo_in = g_row[j-1].lo_out;
      end

      mult_row_p #(
         .WIDTH (WIDTH)
      ) u_row (
         .acc_slice (hi_in),
         .a_op      (a_q),
         .b_bit     (b_q[j]),
         .carry_in  (1'b0),
         .sum       (row_sum),
         .carry     (row_carry)
      );

      assign hi_out = {row_carry, row_sum[WIDTH-1:1]};
      assign lo_out = {row_sum[0], lo_in[WIDTH-1:1]};
   end

   assign row_hi   = g_row[ROWS_PER_CYCLE-1].hi_out;
   assign row_lo   = g_row[ROWS_PER_CYCLE-1].lo_out;
   assign acc_next = {row_hi, row_lo};

   // Next-state, datapath updates and registered output decodes.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      neg_d     = neg_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      cyc_d     = cyc_q;
      product_d = product_q;

      case (state_q)
         StIdle: begin
            if (bus.in_valid && in_ready_q) begin
               // Magnitude of the most negative value wraps to itself, which is
               // the correct unsigned magnitude 2^(WIDTH-1).
               a_d      = (bus.signed_mode && bus.a[WIDTH-1]) ? ~bus.a + WIDTH'(1) : bus.a;
               b_d      = (bus.signed_mode && bus.b[WIDTH-1]) ? ~bus.b + WIDTH'(1) : bus.b;
               neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               acc_hi_d = '0;
               acc_lo_d = '0;
               cyc_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            acc_hi_d = row_hi;
            acc_lo_d = row_lo;
            b_d      = b_q >> ROWS_PER_CYCLE;
            cyc_d    = cyc_q + CntW'(1);
            if (cyc_q == CntW'(NumCycles - 1)) begin
               product_d = neg_q ? ~acc_next + (2*WIDTH)'(1) : acc_next;
               state_d   = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      in_ready_d  = (state_d == StIdle);
      out_valid_d = (state_d == StDone);
      busy_d      = (state_d == StRun) || (state_d == StDone);
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         neg_q       <= 1'b0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         cyc_q       <= '0;
         product_q   <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         neg_q       <= neg_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         cyc_q       <= cyc_d;
         product_q   <= product_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_array_mult.sv
// Bench for seq_array_mult: an 8-bit one-row-per-cycle instance and a 16-bit
// four-rows-per-cycle instance, checked against plain integer multiplication.
module tb_seq_array_mult;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   seq_array_mult_if #(.WIDTH(8))  bus8 ();
   seq_array_mult_if #(.WIDTH(16)) bus16 ();

   seq_array_mult #(.WIDTH(8), .ROWS_PER_CYCLE(1)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   seq_array_mult #(.WIDTH(16), .ROWS_PER_CYCLE(4)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   // Reference: interpret operands at width w (signed or not), multiply, keep 2w bits.
   function automatic longint ref_mul(input int w, input longint a, input longint b,
                                      input bit sgn);
      longint sa = a;
      longint sb = b;
      longint m  = (longint'(1) << (2 * w)) - 1;
      if (sgn && sa[w-1]) sa = sa - (longint'(1) << w);
      if (sgn && sb[w-1]) sb = sb - (longint'(1) << w);
      return (sa * sb) & m;
   endfunction

   // Issue one operation on the 8-bit DUT from a negedge; returns product, latency
   // in clock edges after the accept edge, and whether in_ready rose while busy.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                      input bit do_ack, output logic [15:0] prod, output int lat,
                      output bit rdy_seen);
      int w = 0;
      rdy_seen = 1'b0;
      lat      = 0;
      prod     = 16'hxxxx;
      while (!bus8.in_ready && w < 20) begin @(negedge clk); w++; end
      if (!bus8.in_ready) begin lat = -1; return; end
      bus8.a = a; bus8.b = b; bus8.signed_mode = sgn; bus8.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      while (!bus8.out_valid && lat < 50) begin
         if (bus8.in_ready) rdy_seen = 1'b1;
         @(negedge clk);
         lat++;
      end
      if (bus8.in_ready) rdy_seen = 1'b1;
      prod = bus8.product;
      if (do_ack && bus8.out_valid) begin
         bus8.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus8.out_ready = 1'b0;
      end
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                       output logic [31:0] prod, output int lat);
      int w = 0;
      lat  = 0;
      prod = 32'hxxxxxxxx;
      while (!bus16.in_ready && w < 20) begin @(negedge clk); w++; end
      if (!bus16.in_ready) begin lat = -1; return; end
      bus16.a = a; bus16.b = b; bus16.signed_mode = sgn; bus16.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus16.in_valid = 1'b0;
      while (!bus16.out_valid && lat < 50) begin @(negedge clk); lat++; end
      prod = bus16.product;
      if (bus16.out_valid) begin
         bus16.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus16.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst8_in_ready got %b want 0", bus8.in_ready); end
      n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst8_out_valid got %b want 0", bus8.out_valid); end
      n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL rst8_busy got %b want 0", bus8.busy); end
      n_cmp++; if (bus8.product !== 16'h0) begin n_bad++; $display("FAIL rst8_product got %h want 0", bus8.product); end
      n_cmp++; if (bus16.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst16_in_ready got %b want 0", bus16.in_ready); end
      n_cmp++; if (bus16.product !== 32'h0) begin n_bad++; $display("FAIL rst16_product got %h want 0", bus16.product); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst8_in_ready got %b want 1", bus8.in_ready); end
      n_cmp++; if (bus16.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst16_in_ready got %b want 1", bus16.in_ready); end
   endtask

   task automatic test_directed8();
      logic [7:0]  da [7] = '{8'd13, 8'd255, 8'd0, 8'h80, 8'hFD, 8'd127, 8'hFD};
      logic [7:0]  db [7] = '{8'd11, 8'd255, 8'd200, 8'h80, 8'd5, 8'hFF, 8'd5};
      logic        ds [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [15:0] de [7] = '{16'h008F, 16'hFE01, 16'h0000, 16'h4000, 16'hFFF1, 16'hFF81,
                              16'h04F1};
      logic [15:0] p;
      int          lat;
      bit          rs;
      for (int i = 0; i < 7; i++) begin
         op8(da[i], db[i], ds[i], 1'b1, p, lat, rs);
         n_cmp++; if (p !== de[i]) begin n_bad++; $display("FAIL dir8_product[%0d] got %h want %h", i, p, de[i]); end
         n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL dir8_latency[%0d] got %0d want 8", i, lat); end
         n_cmp++; if (rs !== 1'b0) begin n_bad++; $display("FAIL dir8_in_ready_busy[%0d] got 1 want 0", i); end
      end
   endtask

   task automatic test_random8();
      logic [7:0]  a, b;
      logic        s;
      logic [15:0] p, e;
      int          lat;
      bit          rs;
      for (int i = 0; i < 30; i++) begin
         a = 8'($urandom());
         b = 8'($urandom());
         s = 1'($urandom());
         e = 16'(ref_mul(8, longint'(a), longint'(b), s));
         op8(a, b, s, 1'b1, p, lat, rs);
         n_cmp++; if (p !== e) begin n_bad++; $display("FAIL rnd8_product a=%h b=%h s=%b got %h want %h", a, b, s, p, e); end
         n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL rnd8_latency got %0d want 8", lat); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] p, e;
      int          lat;
      bit          rs;
      e = 16'(ref_mul(8, 64'hC3, 64'h5A, 1'b1));
      op8(8'hC3, 8'h5A, 1'b1, 1'b0, p, lat, rs);
      n_cmp++; if (p !== e) begin n_bad++; $display("FAIL bp_product got %h want %h", p, e); end
      for (int i = 0; i < 5; i++) begin
         bus8.in_valid = 1'b1; bus8.a = 8'd2; bus8.b = 8'd3; bus8.signed_mode = 1'b0;
         @(negedge clk);
         n_cmp++; if (bus8.product !== e) begin n_bad++; $display("FAIL bp_hold_product[%0d] got %h want %h", i, bus8.product, e); end
         n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, bus8.out_valid); end
         n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_in_ready[%0d] got %b want 0", i, bus8.in_ready); end
      end
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.out_ready = 1'b0;
      n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_after_valid got %b want 0", bus8.out_valid); end
      n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_after_in_ready got %b want 1", bus8.in_ready); end
      n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL bp_after_busy got %b want 0", bus8.busy); end
      op8(8'd2, 8'd3, 1'b0, 1'b1, p, lat, rs);
      n_cmp++; if (p !== 16'd6) begin n_bad++; $display("FAIL bp_next_product got %h want 0006", p); end
   endtask

   task automatic test_reset_midrun();
      logic [15:0] p;
      int          lat;
      bit          rs;
      bus8.a = 8'd9; bus8.b = 8'd9; bus8.signed_mode = 1'b0; bus8.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus8.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus8.busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy got %b want 1", bus8.busy); end
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_in_ready got %b want 0", bus8.in_ready); end
      n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_out_valid got %b want 0", bus8.out_valid); end
      n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_busy got %b want 0", bus8.busy); end
      n_cmp++; if (bus8.product !== 16'h0) begin n_bad++; $display("FAIL midrun_rst_product got %h want 0", bus8.product); end
      rst_n = 1'b1;
      @(negedge clk);
      op8(8'd6, 8'd7, 1'b0, 1'b1, p, lat, rs);
      n_cmp++; if (p !== 16'd42) begin n_bad++; $display("FAIL midrun_after_product got %h want 002a", p); end
      n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL midrun_after_latency got %0d want 8", lat); end
   endtask

   task automatic test_wide16();
      logic [15:0] a, b;
      logic        s;
      logic [31:0] p, e;
      int          lat;
      op16(16'd1000, 16'd1000, 1'b0, p, lat);
      n_cmp++; if (p !== 32'h000F4240) begin n_bad++; $display("FAIL w16_1000sq got %h want 000f4240", p); end
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL w16_latency got %0d want 4", lat); end
      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom());
         b = 16'($urandom());
         s = 1'($urandom());
         if (i == 0) begin a = 16'h8000; b = 16'h8000; s = 1'b1; end
         e = 32'(ref_mul(16, longint'(a), longint'(b), s));
         op16(a, b, s, p, lat);
         n_cmp++; if (p !== e) begin n_bad++; $display("FAIL rnd16_product a=%h b=%h s=%b got %h want %h", a, b, s, p, e); end
         n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rnd16_latency got %0d want 4", lat); end
      end
   endtask

   task automatic test_back_to_back16();
      logic [15:0] oa [5];
      logic [15:0] ob [5];
      logic        os [5];
      logic [31:0] expq [$];
      logic [31:0] e;
      int          idx = 0;
      int          got = 0;
      int          last_cyc = -1;
      int          cyc = 0;
      bit          acc;
      for (int i = 0; i < 5; i++) begin
         oa[i] = 16'($urandom()); ob[i] = 16'($urandom()); os[i] = 1'($urandom());
      end
      bus16.out_ready = 1'b1;
      bus16.in_valid  = 1'b1;
      bus16.a = oa[0]; bus16.b = ob[0]; bus16.signed_mode = os[0];
      while (got < 5 && cyc < 200) begin
         if (bus16.out_valid) begin
            if (expq.size() == 0) begin
               n_cmp++; n_bad++; $display("FAIL b2b_unexpected_valid got 1 want 0 at cycle %0d", cyc);
            end else begin
               e = expq.pop_front();
               n_cmp++; if (bus16.product !== e) begin n_bad++; $display("FAIL b2b_product[%0d] got %h want %h", got, bus16.product, e); end
            end
            if (last_cyc >= 0) begin
               n_cmp++; if (cyc - last_cyc !== 6) begin n_bad++; $display("FAIL b2b_period got %0d want 6", cyc - last_cyc); end
            end
            last_cyc = cyc;
            got++;
         end
         acc = bus16.in_valid && bus16.in_ready;
         if (acc) expq.push_back(32'(ref_mul(16, longint'(oa[idx]), longint'(ob[idx]), os[idx])));
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 5) begin
               bus16.a = oa[idx]; bus16.b = ob[idx]; bus16.signed_mode = os[idx];
            end else begin
               bus16.in_valid = 1'b0;
            end
         end
      end
      n_cmp++; if (got !== 5) begin n_bad++; $display("FAIL b2b_count got %0d want 5", got); end
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b0;
   endtask

   initial begin
      bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.signed_mode = 1'b0;
      bus8.out_ready = 1'b0;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.signed_mode = 1'b0;
      bus16.out_ready = 1'b0;
      test_reset();
      test_directed8();
      test_random8();
      test_backpressure();
      test_reset_midrun();
      test_wide16();
      test_back_to_back16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
